// File: rtl/bcd_conv_scheduler_if.sv
// Bus between the RTC-side scheduler and its neighbours: field snapshot inputs,
// the shared BCD converter drive/return pair, and the registered result bank.
interface bcd_conv_scheduler_if #(
  parameter int unsigned N_CAMPOS = 6
);
  logic                    start;
  logic [7*N_CAMPOS-1:0]   campos_bin;
  logic [N_CAMPOS-1:0]     habilita;
  logic [6:0]              conv_bin;
  logic [7:0]              conv_bcd;
  logic [8*N_CAMPOS-1:0]   campos_bcd;
  logic [N_CAMPOS-1:0]     error;
  logic                    busy;
  logic                    done;

  modport master (
    output start, campos_bin, habilita, conv_bcd,
    input  conv_bin, campos_bcd, error, busy, done
  );

  modport slave (
    input  start, campos_bin, habilita, conv_bcd,
    output conv_bin, campos_bcd, error, busy, done
  );
endinterface

// File: rtl/bcd_conv_scheduler.sv
// Time-multiplexes one binary-to-BCD converter across N_CAMPOS snapshotted
// time/date fields, capturing each result into a registered BCD bank.
module bcd_conv_scheduler #(
  parameter int unsigned N_CAMPOS = 6,
  parameter int unsigned ESPERA   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_conv_scheduler_if.slave   bus
);

  localparam int unsigned BIN_W = 7;
  localparam int unsigned BCD_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (N_CAMPOS > 1) ? $clog2(N_CAMPOS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEL    = 3'd1,
    ST_ESPERA = 3'd2,
    ST_CAPT   = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  state_t                        state, state_nxt;
  logic [BIN_W*N_CAMPOS-1:0]     snap_bin, snap_bin_nxt;
  logic [N_CAMPOS-1:0]           snap_hab, snap_hab_nxt;
  logic [IDX_W-1:0]              idx, idx_nxt;
  logic [CNT_W-1:0]              cnt, cnt_nxt;
  logic [BIN_W-1:0]              conv_bin_q, conv_bin_nxt;
  logic [BCD_W*N_CAMPOS-1:0]     bcd_q, bcd_nxt;
  logic [N_CAMPOS-1:0]           err_q, err_nxt;
  logic                          busy_q, busy_nxt;
  logic                          done_q, done_nxt;

  logic [BIN_W-1:0]              fld_bin;
  logic                          fld_hab;
  logic                          last_idx;

  assign bus.conv_bin   = conv_bin_q;
  assign bus.campos_bcd = bcd_q;
  assign bus.error      = err_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  assign last_idx = (idx == IDX_W'(N_CAMPOS - 1));

  // Select the snapshotted field and its enable at the current scan index
  always_comb begin
    fld_bin = '0;
    fld_hab = 1'b0;
    for (int i = 0; i < N_CAMPOS; i++) begin
      if (idx == IDX_W'(i)) begin
        fld_bin = snap_bin[BIN_W*i +: BIN_W];
        fld_hab = snap_hab[i];
      end
    end
  end

  // State and datapath registers; reset aborts any sweep in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      snap_bin   <= '0;
      snap_hab   <= '0;
      idx        <= '0;
      cnt        <= '0;
      conv_bin_q <= '0;
      bcd_q      <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      snap_bin   <= snap_bin_nxt;
      snap_hab   <= snap_hab_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      conv_bin_q <= conv_bin_nxt;
      bcd_q      <= bcd_nxt;
      err_q      <= err_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_SEL;
      end
      ST_SEL: begin
        if (fld_hab)       state_nxt = (ESPERA > 0) ? ST_ESPERA : ST_CAPT;
        else if (last_idx) state_nxt = ST_FIN;
      end
      ST_ESPERA: begin
        if (cnt <= CNT_W'(1)) state_nxt = ST_CAPT;
      end
      ST_CAPT: begin
        state_nxt = last_idx ? ST_FIN : ST_SEL;
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the datapath and registered outputs
  always_comb begin
    snap_bin_nxt = snap_bin;
    snap_hab_nxt = snap_hab;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    conv_bin_nxt = conv_bin_q;
    bcd_nxt      = bcd_q;
    err_nxt      = err_q;
    busy_nxt     = (state_nxt != ST_IDLE);
    done_nxt     = (state_nxt == ST_FIN);

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          snap_bin_nxt = bus.campos_bin;
          snap_hab_nxt = bus.habilita;
          idx_nxt      = '0;
        end
      end
      ST_SEL: begin
        if (fld_hab) begin
          conv_bin_nxt = fld_bin;
          cnt_nxt      = CNT_W'(ESPERA);
        end else if (!last_idx) begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      ST_ESPERA: begin
        cnt_nxt = cnt - CNT_W'(1);
      end
      ST_CAPT: begin
        // Whole-field update so downstream never sees a torn value
        for (int i = 0; i < N_CAMPOS; i++) begin
          if (idx == IDX_W'(i)) begin
            bcd_nxt[BCD_W*i +: BCD_W] = bus.conv_bcd;
            err_nxt[i]                = (bus.conv_bcd == 8'hFF);
          end
        end
        if (!last_idx) idx_nxt = idx + IDX_W'(1);
      end
      default: begin
      end
    endcase
  end

endmodule
